sp_frame_ctrl: RTL and testbench

Frame controller for the serial-to-parallel datapath. It sequences the capture of one serial frame: start detect, bit counting, word assembly, and handoff through a valid/ready port with overrun detection. The block sits between a serial bit source (one bit per `sin_valid` strobe) and a parallel word consumer. It double-buffers, so a new frame can shift in while the previous word waits for acceptance.

---
 rtl/sp_pkg.sv | 12 +
 rtl/sp_frame_ctrl_if.sv | 27 ++
 rtl/sp_shift_reg.sv | 32 +++
 rtl/sp_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_sp_frame_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sp_pkg.sv
// Shared types and limits for the serial-to-parallel frame controller.
package sp_pkg;

  localparam int SP_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } sp_state_t;

endpackage

// File: rtl/sp_frame_ctrl_if.sv
// Frame controller bus: serial bit input, frame start, and the parallel valid/ready word port.
interface sp_frame_ctrl_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  // Master is the surrounding system: it feeds bits and consumes words.
  modport master (
    output start, sin, sin_valid, pout_ready,
    input  pout, pout_valid, busy, overrun, parity_err
  );

  modport slave (
    input  start, sin, sin_valid, pout_ready,
    output pout, pout_valid, busy, overrun, parity_err
  );

endinterface

// File: rtl/sp_shift_reg.sv
// Word assembly shift register; MSB_FIRST selects which end the first received bit ends up in.
module sp_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {q[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign shifted = {bit_in, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/sp_frame_ctrl.sv
// Serial frame controller: start detect, bit counting, double-buffered word handoff with overrun.
// Optional even-parity bit after the data is enabled by defining SP_FRAME_PARITY_EN.
module sp_frame_ctrl
  import sp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sp_frame_ctrl_if.slave      bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > SP_MAX_WIDTH) begin : g_bad_width
      $error("sp_frame_ctrl: WIDTH out of range 2..32");
    end
  endgenerate

  sp_state_t        state;
  logic [CW-1:0]    count;
  logic             busy_r;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] load_word;
  logic             load_perr;
  logic             clr;
  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] pout_r;
  logic             pout_valid_r;
  logic             overrun_r;
  logic             parity_err_r;

  assign clr      = (state == IDLE) && bus.start;
  assign shift_en = (state == SHIFT) && bus.sin_valid;

  sp_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .bit_in   (bus.sin),
    .q        (shift_q)
  );

`ifdef SP_FRAME_PARITY_EN
  // The data word is already complete in the shift register when the parity bit arrives.
  assign complete  = (state == PARITY) && bus.sin_valid;
  assign load_word = shift_q;
  assign load_perr = (^shift_q) ^ bus.sin;
`else
  logic unused_q_edge;

  // Completion coincides with the last data bit, so the word includes the bit being sampled now.
  generate
    if (MSB_FIRST) begin : g_msb_word
      assign load_word     = {shift_q[WIDTH-2:0], bus.sin};
      assign unused_q_edge = shift_q[WIDTH-1];
    end else begin : g_lsb_word
      assign load_word     = {bus.sin, shift_q[WIDTH-1:1]};
      assign unused_q_edge = shift_q[0];
    end
  endgenerate

  assign complete  = shift_en && (count == LAST);
  assign load_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SHIFT;
            count  <= '0;
            busy_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.sin_valid) begin
            count <= count + CW'(1);
            if (count == LAST) begin
`ifdef SP_FRAME_PARITY_EN
              state  <= PARITY;
`else
              state  <= IDLE;
              busy_r <= 1'b0;
`endif
            end
          end
        end
`ifdef SP_FRAME_PARITY_EN
        PARITY: begin
          if (bus.sin_valid) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // A completed word may replace the held one only if the held one is gone or leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout_r       <= '0;
      pout_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else if (complete && (!pout_valid_r || bus.pout_ready)) begin
      pout_r       <= load_word;
      parity_err_r <= load_perr;
      pout_valid_r <= 1'b1;
    end else if (complete) begin
      overrun_r    <= 1'b1;
    end else if (pout_valid_r && bus.pout_ready) begin
      pout_valid_r <= 1'b0;
    end
  end

  assign bus.pout       = pout_r;
  assign bus.pout_valid = pout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;
  assign bus.parity_err = parity_err_r;

endmodule

// File: tb/tb_sp_frame_ctrl.sv
// Directed self-checking bench for sp_frame_ctrl; runs an MSB-first and an LSB-first instance side by side.
module tb_sp_frame_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sin;
  logic sin_valid;
  logic pout_ready;

  int checks   = 0;
  int errors   = 0;
  int accepted = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  sp_frame_ctrl_if #(.WIDTH(WIDTH)) bus_m ();
  sp_frame_ctrl_if #(.WIDTH(WIDTH)) bus_l ();

  assign bus_m.start      = start;
  assign bus_m.sin        = sin;
  assign bus_m.sin_valid  = sin_valid;
  assign bus_m.pout_ready = pout_ready;
  assign bus_l.start      = start;
  assign bus_l.sin        = sin;
  assign bus_l.sin_valid  = sin_valid;
  assign bus_l.pout_ready = pout_ready;

  sp_frame_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  sp_frame_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  // Words handed off by the MSB-first instance, and its valid as seen just before each edge.
  always @(posedge clk) begin
    prev_valid <= bus_m.pout_valid;
    if (!rst && bus_m.pout_valid && bus_m.pout_ready)
      accepted <= accepted + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends one frame MSB of 'word' first; 'rdy_last' drives pout_ready on the completion cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input logic par, input bit gapped, input logic rdy_last);
    start     = 1'b1;
    sin       = ~word[WIDTH-1];
    sin_valid = 1'b1;
    tick();
    start     = 1'b0;
    sin_valid = 1'b0;
    checkOutput("busy_after_start", {31'd0, bus_m.busy}, 32'd1);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      sin       = word[i];
      sin_valid = 1'b1;
`ifndef SP_FRAME_PARITY_EN
      if (i == 0) pout_ready = rdy_last;
`endif
      tick();
      sin_valid = 1'b0;
      if (gapped && i > 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
`ifdef SP_FRAME_PARITY_EN
    sin        = par;
    sin_valid  = 1'b1;
    pout_ready = rdy_last;
    tick();
    sin_valid  = 1'b0;
`else
    if (par === 1'bx) $display("[TB] parity bit unused in this build");
`endif
  endtask

  initial begin
    int acc0;
    rst        = 1'b1;
    start      = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    pout_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_pout",       {24'd0, bus_m.pout}, 32'h0);
    checkOutput("rst_pout_valid", {31'd0, bus_m.pout_valid}, 32'd0);
    checkOutput("rst_busy",       {31'd0, bus_m.busy}, 32'd0);
    checkOutput("rst_overrun",    {31'd0, bus_m.overrun}, 32'd0);
    checkOutput("rst_parity_err", {31'd0, bus_m.parity_err}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic frame A5");
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
    checkOutput("a5_valid_prev",  {31'd0, prev_valid}, 32'd0);
    checkOutput("a5_valid",       {31'd0, bus_m.pout_valid}, 32'd1);
    checkOutput("a5_pout_msb",    {24'd0, bus_m.pout}, 32'hA5);
    checkOutput("a5_pout_lsb",    {24'd0, bus_l.pout}, 32'hA5);
    checkOutput("a5_busy",        {31'd0, bus_m.busy}, 32'd0);
    checkOutput("a5_parity_err",  {31'd0, bus_m.parity_err}, 32'd0);
    tick();
    checkOutput("a5_valid_drop",  {31'd0, bus_m.pout_valid}, 32'd0);

    $display("[TB] first bit only");
    applyStimulus(8'h80, 1'b1, 1'b0, 1'b1);
    checkOutput("b80_pout_msb",   {24'd0, bus_m.pout}, 32'h80);
    checkOutput("b80_pout_lsb",   {24'd0, bus_l.pout}, 32'h01);
    tick();

    $display("[TB] overrun with consumer stalled");
    pout_ready = 1'b0;
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("ov_first_valid", {31'd0, bus_m.pout_valid}, 32'd1);
    checkOutput("ov_first_pout",  {24'd0, bus_m.pout}, 32'h3C);
    checkOutput("ov_first_flag",  {31'd0, bus_m.overrun}, 32'd0);
    applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0);
    checkOutput("ov_kept_pout",   {24'd0, bus_m.pout}, 32'h3C);
    checkOutput("ov_kept_lsb",    {24'd0, bus_l.pout}, 32'h3C);
    checkOutput("ov_kept_valid",  {31'd0, bus_m.pout_valid}, 32'd1);
    checkOutput("ov_flag_set",    {31'd0, bus_m.overrun}, 32'd1);
    pout_ready = 1'b1;
    tick();
    checkOutput("ov_accept_drop", {31'd0, bus_m.pout_valid}, 32'd0);
    checkOutput("ov_flag_sticky", {31'd0, bus_m.overrun}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("ov_flag_cleared", {31'd0, bus_m.overrun}, 32'd0);

    $display("[TB] completion coincides with acceptance");
    pout_ready = 1'b0;
    applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0);
    checkOutput("co_first_pout",  {24'd0, bus_m.pout}, 32'hAA);
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1);
    checkOutput("co_valid",       {31'd0, bus_m.pout_valid}, 32'd1);
    checkOutput("co_pout_msb",    {24'd0, bus_m.pout}, 32'h55);
    checkOutput("co_pout_lsb",    {24'd0, bus_l.pout}, 32'hAA);
    checkOutput("co_overrun",     {31'd0, bus_m.overrun}, 32'd0);
    tick();
    checkOutput("co_valid_drop",  {31'd0, bus_m.pout_valid}, 32'd0);

    $display("[TB] reset mid-frame then gapped frame");
    pout_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin       = 1'b1;
      sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mr_busy",        {31'd0, bus_m.busy}, 32'd0);
    checkOutput("mr_valid",       {31'd0, bus_m.pout_valid}, 32'd0);
    acc0 = accepted;
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1);
    checkOutput("mr_pout",        {24'd0, bus_m.pout}, 32'hFF);
    checkOutput("mr_valid_full",  {31'd0, bus_m.pout_valid}, 32'd1);
    tick();
    checkOutput("mr_word_count",  accepted - acc0, 32'd1);
    checkOutput("mr_valid_drop",  {31'd0, bus_m.pout_valid}, 32'd0);

`ifdef SP_FRAME_PARITY_EN
    $display("[TB] parity status");
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
    checkOutput("par_good_err",   {31'd0, bus_m.parity_err}, 32'd0);
    checkOutput("par_good_pout",  {24'd0, bus_m.pout}, 32'h07);
    tick();
    applyStimulus(8'h07, 1'b0, 1'b0, 1'b1);
    checkOutput("par_bad_err",    {31'd0, bus_m.parity_err}, 32'd1);
    checkOutput("par_bad_valid",  {31'd0, bus_m.pout_valid}, 32'd1);
    checkOutput("par_bad_pout",   {24'd0, bus_m.pout}, 32'h07);
    tick();
`else
    checkOutput("noparity_err",   {31'd0, bus_m.parity_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
